decode_ctrl_pipe: RTL
=====================

# decode_ctrl_pipe

Parametrised decode-and-control stage for the pipelined RV32I core. Decodes the full RV32I base set plus optional M-extension ops and registers all control signals into the ID/EX boundary. Handles stall and flush, and sequences multi-cycle MUL/DIV ops with an internal busy counter that back-pressures fetch/decode. Sits between the IF/ID register and the execute stage; it replaces the single-cycle combinational control decoder.

## Interface
- MUL_LATENCY, default 3: execute cycles for MUL* ops (≥1).
- DIV_LATENCY, default 33: execute cycles for DIV*/REM* ops (≥1).
- EN_MEXT, default 1: 1 = decode M-extension; 0 = M ops are illegal.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instr_i  in  32  instruction in decode.
- valid_i  in  1  instr_i holds a real instruction.
- stall_i  in  1  hazard-unit stall; hold E registers.
- flush_i  in  1  insert bubble into E (branch taken / jump).
- ImmSrcD  out  3  combinational immediate format for the extend unit: 000 I, 001 S, 010 B, 011 J, 100 U.
- RegWriteE  out  1  registered register-file write enable.
- MemWriteE  out  1  registered store enable.
- MemSizeE  out  3  registered funct3 for load/store sizing.
- ResultSrcE  out  2  registered result source: 00 ALU, 01 memory, 10 PC+4.
- ALUCtrlE  out  4  registered ALU op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASS_B, 1111 NOP.
- ALUSrcE  out  1  registered ALU B select: 1 = immediate.
- ASrcPCE  out  1  registered ALU A select: 1 = PC (AUIPC).
- BranchE / JumpE / JalrE  out  1 each  registered control-flow flags.
- BranchTypeE  out  3  registered funct3 of the branch.
- MulDivE  out  1  registered: E holds an M-extension op.
- ValidE  out  1  registered: E holds a real instruction.
- illegal_o  out  1  registered: decoded opcode/funct is unsupported.
- busy_o  out  1  multi-cycle unit occupied; upstream must hold.

## Operation
- Decode covers LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, and OP.
- OP with funct7 = 0000001 is an M op.
- SUB/SRA are selected by instr_i[30]. SRAI/SRLI are selected by instr_i[30].
- LUI: PASS_B with U immediate.
- JAL/JALR: ResultSrc 10, RegWrite 1.
- Illegal or invalid instruction:
  - All write enables, Branch, Jump and MulDiv are 0.
  - ALUCtrl is NOP. ValidE is 0.
  - illegal_o = 1 only if valid_i is 1 and the instruction is illegal.
- Load priority per cycle: reset > flush_i > (stall_i | busy_o) hold > load decode.
- FSM states:
  - IDLE: if an M op with valid_i is loaded and the selected latency is >1, go to BUSY with cnt = LAT−1.
  - BUSY: busy_o = 1 and E registers hold. cnt decrements each cycle. When cnt = 1, go to IDLE next edge.
  - flush_i in BUSY: go to IDLE, cnt = 0, bubble into E.
- Latency select: DIV_LATENCY when funct3[2] = 1, else MUL_LATENCY.
- cnt width is $clog2(max(MUL_LATENCY, DIV_LATENCY)+1). It never wraps below 0.
- stall_i during BUSY: counting continues and E holds. Leaving BUSY does not release the stall_i hold.

## Timing
- E outputs have 1-cycle latency from decode; ImmSrcD is 0-cycle combinational.
- busy_o is driven combinationally from state. It rises in the cycle after the M op is loaded and stays high for LAT−1 cycles.
- LAT = 1: the op behaves as single-cycle and busy_o is never asserted.
- Reset values:
  - All registered outputs 0, except ALUCtrlE = 1111.
  - State IDLE, cnt 0, busy_o 0.
- Reset asserted mid-BUSY: IDLE on the next edge.
- flush_i and stall_i together: flush wins.

## Structure
- Shared package `ctrl_pkg`: ALU op, ImmSrc and ResultSrc enums; opcode localparams; the M-op funct7 constant; the FSM state enum.
- One sub-module `ctrl_decode`: purely combinational instruction → control bundle (packed struct from `ctrl_pkg`).
- The top level holds the E register, the FSM and the counter.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles → all outputs 0, ALUCtrlE = 1111, busy_o = 0.
- addi x1, x0, 5 (0x00500093), valid_i = 1 → next cycle RegWriteE = 1, ALUSrcE = 1, ALUCtrlE = 0000, ValidE = 1; ImmSrcD = 000 the same cycle.
- sub, sw, beq, jal, lui in sequence:
  - sub → ALUCtrlE 0001.
  - sw → MemWriteE 1, RegWriteE 0.
  - beq → BranchE 1, BranchTypeE 000.
  - jal → ResultSrcE 10, JumpE 1.
  - lui → ALUCtrlE 1010.
- div (funct3 = 100), DIV_LATENCY = 33 → busy_o high for exactly 32 cycles, E held; mul with MUL_LATENCY = 1 → busy_o never asserted.
- flush_i asserted on cycle 5 of a DIV → next cycle IDLE, busy_o 0, ValidE 0, RegWriteE 0.
- Opcode 0x7F, or M op with EN_MEXT = 0 → illegal_o 1, all enables 0; stall_i + flush_i together → bubble.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-stage types: ALU/immediate/result encodings, opcodes and the E-stage control bundle.
// No logic beyond two small helper functions; no latency or backpressure of its own.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SLTU   = 4'b0110,
    ALU_SLL    = 4'b0111,
    ALU_SRL    = 4'b1000,
    ALU_SRA    = 4'b1001,
    ALU_PASS_B = 4'b1010,
    ALU_NOP    = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [2:0]  mem_size;
    result_src_e result_src;
    alu_op_e     alu_ctrl;
    logic        alu_src;
    logic        a_src_pc;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  branch_type;
    logic        mul_div;
    logic        illegal;
  } ctrl_t;

  function automatic ctrl_t ctrl_bubble();
    ctrl_t c;
    c          = '0;
    c.alu_ctrl = ALU_NOP;
    return c;
  endfunction

  // alt is instr[30]: picks SUB over ADD and SRA over SRL
  function automatic alu_op_e alu_from_f3(logic [2:0] f3, logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// Decode-stage bus: instruction/hazard controls in, ImmSrcD and registered E-stage controls out.
// busy_o is the backpressure to fetch/decode; upstream must hold instr_i while it is high.
interface decode_ctrl_pipe_if;
  logic [31:0] instr_i;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic [2:0]  ImmSrcD;
  logic        RegWriteE;
  logic        MemWriteE;
  logic [2:0]  MemSizeE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUCtrlE;
  logic        ALUSrcE;
  logic        ASrcPCE;
  logic        BranchE;
  logic        JumpE;
  logic        JalrE;
  logic [2:0]  BranchTypeE;
  logic        MulDivE;
  logic        ValidE;
  logic        illegal_o;
  logic        busy_o;

  modport master (
    output instr_i, valid_i, stall_i, flush_i,
    input  ImmSrcD, RegWriteE, MemWriteE, MemSizeE, ResultSrcE, ALUCtrlE, ALUSrcE,
           ASrcPCE, BranchE, JumpE, JalrE, BranchTypeE, MulDivE, ValidE, illegal_o, busy_o
  );

  modport slave (
    input  instr_i, valid_i, stall_i, flush_i,
    output ImmSrcD, RegWriteE, MemWriteE, MemSizeE, ResultSrcE, ALUCtrlE, ALUSrcE,
           ASrcPCE, BranchE, JumpE, JalrE, BranchTypeE, MulDivE, ValidE, illegal_o, busy_o
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational RV32I(+M) decoder: opcode/funct fields to control bundle and immediate format.
// Zero latency, no state, no backpressure; illegal encodings come out as a bubble with illegal set.
module ctrl_decode #(
  parameter bit EN_MEXT = 1'b1
) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  output ctrl_pkg::ctrl_t   ctrl,
  output ctrl_pkg::imm_src_e imm_src
);
  import ctrl_pkg::*;

  ctrl_t c;

  always_comb begin
    c       = ctrl_bubble();
    imm_src = IMM_I;
    case (opcode)
      OPC_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_PASS_B;
        imm_src     = IMM_U;
      end
      OPC_AUIPC: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.a_src_pc  = 1'b1;
        c.alu_ctrl  = ALU_ADD;
        imm_src     = IMM_U;
      end
      OPC_JAL: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_PC4;
        c.jump       = 1'b1;
        c.alu_src    = 1'b1;
        c.a_src_pc   = 1'b1;
        c.alu_ctrl   = ALU_ADD;
        imm_src      = IMM_J;
      end
      OPC_JALR: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_PC4;
        c.jump       = 1'b1;
        c.jalr       = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_ctrl   = ALU_ADD;
        c.illegal    = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        c.branch      = 1'b1;
        c.branch_type = funct3;
        c.alu_ctrl    = ALU_SUB;
        imm_src       = IMM_B;
        c.illegal     = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_MEM;
        c.alu_src    = 1'b1;
        c.alu_ctrl   = ALU_ADD;
        c.mem_size   = funct3;
        c.illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = ALU_ADD;
        c.mem_size  = funct3;
        imm_src     = IMM_S;
        c.illegal   = funct3[2] || (funct3 == 3'b011);
      end
      OPC_OPIMM: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        // bit 30 of an ADDI is immediate data, so only the right shift honours it
        c.alu_ctrl  = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        c.illegal   = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                      ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
      end
      OPC_OP: begin
        c.reg_write = 1'b1;
        if (funct7 == F7_MEXT) begin
          c.mul_div  = 1'b1;
          c.alu_ctrl = ALU_NOP;
          c.illegal  = !EN_MEXT;
        end else begin
          c.alu_ctrl = alu_from_f3(funct3, funct7[5]);
          c.illegal  = !((funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        end
      end
      default: c.illegal = 1'b1;
    endcase

    if (c.illegal) begin
      c         = ctrl_bubble();
      c.illegal = 1'b1;
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode/control stage: registers decoded controls into ID/EX; 1-cycle latency, ImmSrcD combinational.
// Holds E on stall_i or busy_o; busy_o covers LAT-1 cycles after a multi-cycle MUL/DIV is loaded.
module decode_ctrl_pipe #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 33,
  parameter bit EN_MEXT     = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  decode_ctrl_pipe_if.slave bus
);
  import ctrl_pkg::*;

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);

  ctrl_t           dec;
  ctrl_t           load_val;
  ctrl_t           e_q;
  logic            e_valid;
  imm_src_e        imm_src;
  state_e          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   lat_m1;
  logic            busy;
  logic            unused_instr_bits;

  ctrl_decode #(.EN_MEXT(EN_MEXT)) u_decode (
    .opcode  (bus.instr_i[6:0]),
    .funct3  (bus.instr_i[14:12]),
    .funct7  (bus.instr_i[31:25]),
    .ctrl    (dec),
    .imm_src (imm_src)
  );

  assign unused_instr_bits = ^{bus.instr_i[24:15], bus.instr_i[11:7]};

  assign lat_m1 = bus.instr_i[14] ? CW'(DIV_LATENCY - 1) : CW'(MUL_LATENCY - 1);
  assign busy   = (state == ST_BUSY);

  // dec is already a bubble (with illegal set) for bad encodings; invalid slots clear illegal too
  always_comb begin
    load_val = dec;
    if (!bus.valid_i) load_val = ctrl_bubble();
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q     <= ctrl_bubble();
      e_valid <= 1'b0;
      state   <= ST_IDLE;
      cnt     <= '0;
    end else if (bus.flush_i) begin
      e_q     <= ctrl_bubble();
      e_valid <= 1'b0;
      state   <= ST_IDLE;
      cnt     <= '0;
    end else if (bus.stall_i || busy) begin
      // counting runs through a stall; E stays put either way
      if (state == ST_BUSY) begin
        if (cnt <= CW'(1)) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end else begin
      e_q     <= load_val;
      e_valid <= bus.valid_i && !dec.illegal;
      if (bus.valid_i && dec.mul_div && (lat_m1 != '0)) begin
        state <= ST_BUSY;
        cnt   <= lat_m1;
      end
    end
  end

  assign bus.ImmSrcD     = imm_src;
  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.MemSizeE    = e_q.mem_size;
  assign bus.ResultSrcE  = e_q.result_src;
  assign bus.ALUCtrlE    = e_q.alu_ctrl;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.ASrcPCE     = e_q.a_src_pc;
  assign bus.BranchE     = e_q.branch;
  assign bus.JumpE       = e_q.jump;
  assign bus.JalrE       = e_q.jalr;
  assign bus.BranchTypeE = e_q.branch_type;
  assign bus.MulDivE     = e_q.mul_div;
  assign bus.ValidE      = e_valid;
  assign bus.illegal_o   = e_q.illegal;
  assign bus.busy_o      = busy;

endmodule
